// File: rtl/kyber_ntt_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : kyber_ntt_ctrl_if
//  Description : Bundle of the NTT sequencer's handshake and RAM/butterfly
//                control signals.
//                  start, stall           host -> controller
//                  busy, done             controller -> host
//                  rd_en, rd_addr_a/b     read side of the coefficient RAM
//                  zeta_idx, bf_valid     butterfly input side
//                  wr_en, wr_addr_a/b     write-back side of the RAM
//                  layer                  current NTT layer (0..6)
//                Optional macro NTT_CTRL_INTT_EN adds inverse (in) and
//                bf_mode (out).
//                Modport master: controller view. Modport slave: environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface kyber_ntt_ctrl_if;
    logic       start;
    logic       stall;
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [7:0] rd_addr_a;
    logic [7:0] rd_addr_b;
    logic [6:0] zeta_idx;
    logic       bf_valid;
    logic       wr_en;
    logic [7:0] wr_addr_a;
    logic [7:0] wr_addr_b;
    logic [2:0] layer;
`ifdef NTT_CTRL_INTT_EN
    logic       inverse;
    logic       bf_mode;

    modport master (
        input  start, stall, inverse,
        output busy, done, rd_en, rd_addr_a, rd_addr_b, zeta_idx, bf_valid,
               wr_en, wr_addr_a, wr_addr_b, layer, bf_mode
    );
    modport slave (
        output start, stall, inverse,
        input  busy, done, rd_en, rd_addr_a, rd_addr_b, zeta_idx, bf_valid,
               wr_en, wr_addr_a, wr_addr_b, layer, bf_mode
    );
`else
    modport master (
        input  start, stall,
        output busy, done, rd_en, rd_addr_a, rd_addr_b, zeta_idx, bf_valid,
               wr_en, wr_addr_a, wr_addr_b, layer
    );
    modport slave (
        output start, stall,
        input  busy, done, rd_en, rd_addr_a, rd_addr_b, zeta_idx, bf_valid,
               wr_en, wr_addr_a, wr_addr_b, layer
    );
`endif
endinterface
`default_nettype wire

// File: rtl/kyber_ntt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : kyber_ntt_ctrl
//  Description : Sequencer for the Kyber NTT accelerator. Walks 7 layers of
//                128 butterflies over the 256-entry coefficient RAM, one
//                butterfly per cycle, and writes results back 1+BF_LAT cycles
//                after issue.
//  Ports       : clk  - system clock (rising edge)
//                rst  - synchronous active-high reset
//                bus  - kyber_ntt_ctrl_if.master (start/stall in, busy/done,
//                       read/write addresses, zeta index, layer out)
//  Parameters  : N      - polynomial length (256)
//                BF_LAT - butterfly latency in cycles (>=1)
//  Macro       : NTT_CTRL_INTT_EN - enables inverse-NTT ordering (inverse
//                input latched at start, bf_mode output)
//  Revision    : 1.0 - initial release
// ============================================================================
module kyber_ntt_ctrl #(
    parameter int N      = 256,
    parameter int BF_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    kyber_ntt_ctrl_if.master bus
);
    // Stage 1 feeds the butterfly, stage c_depth carries the write-back.
    localparam int               c_depth      = 1 + BF_LAT;
    localparam int               c_dcw        = $clog2(c_depth + 1);
    localparam logic [6:0]       c_last_b     = 7'(N / 2 - 1);
    localparam logic [2:0]       c_last_layer = 3'd6;
    localparam logic [c_dcw-1:0] c_drain_last = c_dcw'(c_depth - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [6:0]       r_b, w_b_nxt;
    logic [2:0]       r_layer, w_layer_nxt;
    logic [c_dcw-1:0] r_drain, w_drain_nxt;
    logic             w_issue, w_busy, w_done;
    logic             r_inv, w_inv_nxt;

    // ------------------------------------------------------------------
    // Address generation. len = 1 << w_len_log is the butterfly span.
    // ------------------------------------------------------------------
    logic [3:0] w_len_log;
    logic [7:0] w_b8, w_g, w_len, w_rd_a, w_rd_b, w_rd_a_q, w_rd_b_q;
    logic [6:0] w_zeta, w_zeta_q;

    always_comb begin
        w_b8      = {1'b0, r_b};
        w_len_log = 4'd7 - {1'b0, r_layer};
        if (r_inv) begin
            w_len_log = {1'b0, r_layer} + 4'd1;
        end
        w_g    = w_b8 >> w_len_log;
        w_len  = 8'd1 << w_len_log;
        // Group base is 2*len*g; when len=128 the only group is g=0.
        w_rd_a = (w_g << (w_len_log + 4'd1)) | (w_b8 & (w_len - 8'd1));
        w_rd_b = w_rd_a + w_len;
        w_zeta = (7'd1 << r_layer) + w_g[6:0];
        if (r_inv) begin
            // (256/len) - 1 - g with len = 2 << layer reduces to (127 >> layer) - g.
            w_zeta = (7'd127 >> r_layer) - w_g[6:0];
        end
    end

    // Idle/stalled cycles present zero addresses and push zero into the pipe.
    assign w_rd_a_q = w_issue ? w_rd_a : 8'd0;
    assign w_rd_b_q = w_issue ? w_rd_b : 8'd0;
    assign w_zeta_q = w_issue ? w_zeta : 7'd0;

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_b     <= 7'd0;
            r_layer <= 3'd0;
            r_drain <= '0;
            r_inv   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_b     <= w_b_nxt;
            r_layer <= w_layer_nxt;
            r_drain <= w_drain_nxt;
            r_inv   <= w_inv_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_b_nxt     = r_b;
        w_layer_nxt = r_layer;
        w_drain_nxt = r_drain;
        w_inv_nxt   = r_inv;
        w_issue     = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_ISSUE;
                    w_b_nxt     = 7'd0;
                    w_layer_nxt = 3'd0;
                    w_drain_nxt = '0;
`ifdef NTT_CTRL_INTT_EN
                    w_inv_nxt   = bus.inverse;
`else
                    w_inv_nxt   = 1'b0;
`endif
                end
            end
            S_ISSUE: begin
                w_busy = 1'b1;
                if (!bus.stall) begin
                    w_issue = 1'b1;
                    if (r_b == c_last_b) begin
                        w_state_nxt = S_DRAIN;
                        w_b_nxt     = 7'd0;
                        w_drain_nxt = '0;
                    end else begin
                        w_b_nxt = r_b + 7'd1;
                    end
                end
            end
            S_DRAIN: begin
                // Wait for the last write of the layer before the next read.
                w_busy = 1'b1;
                if (r_drain == c_drain_last) begin
                    w_drain_nxt = '0;
                    if (r_layer == c_last_layer) begin
                        w_state_nxt = S_FIN;
                    end else begin
                        w_state_nxt = S_ISSUE;
                        w_layer_nxt = r_layer + 3'd1;
                    end
                end else begin
                    w_drain_nxt = r_drain + 1'b1;
                end
            end
            S_FIN: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Issue pipeline: always advances, so in-flight work finishes during
    // stalls; stall bubbles enter as valid=0.
    // ------------------------------------------------------------------
    logic       r_pv [1:c_depth];
    logic [7:0] r_pa [1:c_depth];
    logic [7:0] r_pb [1:c_depth];
    logic [6:0] r_zeta;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= c_depth; i++) begin
                r_pv[i] <= 1'b0;
                r_pa[i] <= 8'd0;
                r_pb[i] <= 8'd0;
            end
            r_zeta <= 7'd0;
        end else begin
            r_pv[1] <= w_issue;
            r_pa[1] <= w_rd_a_q;
            r_pb[1] <= w_rd_b_q;
            r_zeta  <= w_zeta_q;
            for (int i = 2; i <= c_depth; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pa[i] <= r_pa[i-1];
                r_pb[i] <= r_pb[i-1];
            end
        end
    end

    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.rd_en     = w_issue;
    assign bus.rd_addr_a = w_rd_a_q;
    assign bus.rd_addr_b = w_rd_b_q;
    assign bus.zeta_idx  = r_zeta;
    assign bus.bf_valid  = r_pv[1];
    assign bus.wr_en     = r_pv[c_depth];
    assign bus.wr_addr_a = r_pa[c_depth];
    assign bus.wr_addr_b = r_pb[c_depth];
    assign bus.layer     = r_layer;
`ifdef NTT_CTRL_INTT_EN
    assign bus.bf_mode   = r_inv;
`endif

endmodule
`default_nettype wire

// File: tb/tb_kyber_ntt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kyber_ntt_ctrl
//  Description : Self-checking bench for kyber_ntt_ctrl. A reference model
//                built from the textbook Kyber NTT loops produces the
//                expected read order; reads, zeta indices and write-backs
//                are checked through queues as the DUT produces them.
//                Honours NTT_CTRL_INTT_EN for the inverse run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_kyber_ntt_ctrl;
    localparam int BF_LAT = 3;
    localparam int D      = BF_LAT + 1;
    localparam int N_BF   = 7 * 128;
    localparam int T_DONE = 1 + 7 * (128 + D);

    logic clk = 1'b0;
    logic rst;

    kyber_ntt_ctrl_if ifc ();

    kyber_ntt_ctrl #(.N(256), .BF_LAT(BF_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int z;
        int l;
        bit first;
        int t;
    } exp_t;

    exp_t rq[$];
    exp_t zq[$];
    exp_t wq[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t0       = 0;
    bit mon_en   = 1'b0;
    bit exp_mode = 1'b0;
    int rd_cnt, wr_cnt, busy_cnt, first_busy, done_cyc, done_cnt, wr_stall, mode_bad;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Canonical Kyber loop nest: groups of 2*len, one zeta per group.
    function automatic void build_model(input bit inv);
        int   len;
        int   k;
        exp_t e;
        rq.delete();
        k = inv ? 127 : 1;
        for (int l = 0; l < 7; l++) begin
            len = inv ? (2 << l) : (128 >> l);
            for (int s = 0; s < 256; s += 2 * len) begin
                for (int j = s; j < s + len; j++) begin
                    e.a     = j;
                    e.b     = j + len;
                    e.z     = k;
                    e.l     = l;
                    e.first = (j == 0);
                    e.t     = 0;
                    rq.push_back(e);
                end
                k = inv ? k - 1 : k + 1;
            end
        end
    endfunction

    exp_t m_e;
    int   m_c;
    always @(negedge clk) begin
        if (mon_en) begin
            m_c = cyc - t0 + 1;
            if (ifc.busy) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = m_c;
`ifdef NTT_CTRL_INTT_EN
                if (ifc.bf_mode != exp_mode) mode_bad++;
`endif
            end
            if (ifc.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = m_c;
            end
            if (ifc.stall) check_val("rd_en_in_stall", int'(ifc.rd_en), 0);
            if (ifc.rd_en) begin
                rd_cnt++;
                if (rq.size() == 0) begin
                    check_val("rd_extra", 1, 0);
                end else begin
                    m_e = rq.pop_front();
                    // A layer's first read must see no write still pending.
                    if (m_e.first) check_val("raw_pending_wr", wq.size(), 0);
                    check_val("rd_addr_a", int'(ifc.rd_addr_a), m_e.a);
                    check_val("rd_addr_b", int'(ifc.rd_addr_b), m_e.b);
                    check_val("layer", int'(ifc.layer), m_e.l);
                    m_e.t = m_c + 1;
                    zq.push_back(m_e);
                    m_e.t = m_c + D;
                    wq.push_back(m_e);
                end
            end
            if (ifc.bf_valid) begin
                if (zq.size() == 0) begin
                    check_val("bf_extra", 1, 0);
                end else begin
                    m_e = zq.pop_front();
                    check_val("zeta_idx", int'(ifc.zeta_idx), m_e.z);
                    check_val("bf_time", m_c, m_e.t);
                end
            end
            if (ifc.wr_en) begin
                wr_cnt++;
                if (ifc.stall) wr_stall++;
                if (wq.size() == 0) begin
                    check_val("wr_extra", 1, 0);
                end else begin
                    m_e = wq.pop_front();
                    check_val("wr_addr_a", int'(ifc.wr_addr_a), m_e.a);
                    check_val("wr_addr_b", int'(ifc.wr_addr_b), m_e.b);
                    check_val("wr_time", m_c, m_e.t);
                end
            end
        end
    end

    task automatic clear_stats(input bit inv);
        build_model(inv);
        zq.delete();
        wq.delete();
        rd_cnt = 0; wr_cnt = 0; busy_cnt = 0; first_busy = -1;
        done_cyc = -1; done_cnt = 0; wr_stall = 0; mode_bad = 0;
        exp_mode = inv;
    endtask

    // Pulse start for one cycle; afterwards we are in cycle 1.
    task automatic kick(input bit inv);
        @(posedge clk); #1;
        ifc.start = 1'b1;
`ifdef NTT_CTRL_INTT_EN
        ifc.inverse = inv;
`endif
        @(posedge clk); #1;
        t0        = cyc;
        mon_en    = 1'b1;
        ifc.start = 1'b0;
`ifdef NTT_CTRL_INTT_EN
        ifc.inverse = ~inv;
`endif
    endtask

    task automatic check_reset_outputs();
        check_val("rst_busy",      int'(ifc.busy), 0);
        check_val("rst_done",      int'(ifc.done), 0);
        check_val("rst_rd_en",     int'(ifc.rd_en), 0);
        check_val("rst_bf_valid",  int'(ifc.bf_valid), 0);
        check_val("rst_wr_en",     int'(ifc.wr_en), 0);
        check_val("rst_rd_addr_a", int'(ifc.rd_addr_a), 0);
        check_val("rst_rd_addr_b", int'(ifc.rd_addr_b), 0);
        check_val("rst_zeta_idx",  int'(ifc.zeta_idx), 0);
        check_val("rst_wr_addr_a", int'(ifc.wr_addr_a), 0);
        check_val("rst_wr_addr_b", int'(ifc.wr_addr_b), 0);
        check_val("rst_layer",     int'(ifc.layer), 0);
    endtask

    task automatic run_xform(input bit inv, input int st_at, input int st_len, input int exp_done);
        clear_stats(inv);
        kick(inv);
        for (int k = 1; k <= exp_done + 100 && done_cyc < 0; k++) begin
            ifc.stall = (k >= st_at && k < st_at + st_len);
            ifc.start = (k == 10);  // must be ignored while busy
            @(posedge clk); #1;
        end
        ifc.stall = 1'b0;
        ifc.start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        mon_en = 1'b0;
        check_val("done_cycle", done_cyc, exp_done);
        check_val("done_pulses", done_cnt, 1);
        check_val("busy_first", first_busy, 1);
        check_val("busy_cycles", busy_cnt, exp_done - 1);
        check_val("rd_count", rd_cnt, N_BF);
        check_val("wr_count", wr_cnt, N_BF);
        check_val("rd_left", rq.size(), 0);
        check_val("bf_left", zq.size(), 0);
        check_val("wr_left", wq.size(), 0);
        if (st_len > 0) check_val("wr_in_stall", wr_stall, D);
`ifdef NTT_CTRL_INTT_EN
        check_val("bf_mode_bad", mode_bad, 0);
`endif
    endtask

    int quiet;

    initial begin
        rst       = 1'b1;
        ifc.start = 1'b0;
        ifc.stall = 1'b0;
`ifdef NTT_CTRL_INTT_EN
        ifc.inverse = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;

        run_xform(1'b0, 0, 0, T_DONE);
        // Ten stall cycles in the middle of layer 3 (issue cycles 397..524).
        run_xform(1'b0, 450, 10, T_DONE + 10);

        // Reset during layer 2 with writes in flight.
        clear_stats(1'b0);
        kick(1'b0);
        for (int k = 1; k < 300; k++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst    = 1'b0;
        mon_en = 1'b0;
        check_reset_outputs();
        quiet = 0;
        repeat (6) begin
            @(negedge clk);
            if (ifc.wr_en || ifc.bf_valid || ifc.busy || ifc.rd_en) quiet++;
        end
        check_val("post_rst_quiet", quiet, 0);

        run_xform(1'b0, 0, 0, T_DONE);
`ifdef NTT_CTRL_INTT_EN
        run_xform(1'b1, 0, 0, T_DONE);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
